// File: rtl/elastic_buffer.sv
// Elastic buffer: circular store of depth words on a valid/ready stream,
// with a registered upstream_ready, an occupancy count and an almost-full flag.
module elastic_buffer #(
  parameter int bits              = 32,
  parameter int depth             = 4,
  parameter int almost_full_level = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [bits-1:0]            upstream_data,
  input  logic                       upstream_valid,
  output logic                       upstream_ready,
  output logic [bits-1:0]            downstream_data,
  output logic                       downstream_valid,
  input  logic                       downstream_ready,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam logic [CW-1:0] FULL_C = CW'(depth);
  localparam logic [CW-1:0] AFL_C  = CW'(almost_full_level);

  logic [bits-1:0] mem_q [depth];
  logic [PW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ready_q;
  logic            wr, rd;

  assign wr = upstream_valid & ready_q;
  assign rd = (count_q != '0) & downstream_ready;

  always_comb begin
    count_d = count_q;
    unique case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ready is loaded from the next occupancy so it never sits on a comb path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (wr) begin
        mem_q[wp_q] <= upstream_data;
        wp_q        <= wp_q + 1'b1;
      end
      if (rd) rp_q <= rp_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != FULL_C);
    end
  end

  assign upstream_ready   = ready_q;
  assign downstream_data  = mem_q[rp_q];
  assign downstream_valid = (count_q != '0);
  assign count            = count_q;
  assign almost_full      = (count_q >= AFL_C);

endmodule

// File: tb/tb_elastic_buffer.sv
// Directed bench for elastic_buffer: queue model checked every cycle,
// plus literal expectations for fill, drain, overlap, stream and reset.
module tb_elastic_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  up_data = '0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [W-1:0]  dn_data;
  logic          dn_valid;
  logic          dn_ready = 1'b0;
  logic [CW-1:0] count;
  logic          almost_full;

  elastic_buffer #(.bits(W), .depth(DEPTH), .almost_full_level(AFL)) dut (
    .clk              (clk),
    .rst              (rst),
    .upstream_data    (up_data),
    .upstream_valid   (up_valid),
    .upstream_ready   (up_ready),
    .downstream_data  (dn_data),
    .downstream_valid (dn_valid),
    .downstream_ready (dn_ready),
    .count            (count),
    .almost_full      (almost_full)
  );

  always #5 if (clk_en) clk = ~clk;

  int total = 0;
  int bad   = 0;
  int maxc  = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] rx[$];

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("valid", W'(dn_valid), W'(q.size() != 0));
    chk("count", W'(count), W'(q.size()));
    chk("ready", W'(up_ready), W'(q.size() != DEPTH));
    chk("afull", W'(almost_full), W'(q.size() >= AFL));
    if (q.size() != 0) chk("head", dn_data, q[0]);
    if (int'(count) > maxc) maxc = int'(count);
  endtask

  // one cycle: drive, let the edge happen, update model, check at negedge
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r,
                     output logic wr, output logic rd);
    up_valid = v;
    up_data  = d;
    dn_ready = r;
    wr = v && (q.size() < DEPTH);
    rd = r && (q.size() > 0);
    if (rd) begin
      chk("rd_data", dn_data, q[0]);
      rx.push_back(dn_data);
    end
    @(posedge clk);
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(d);
    @(negedge clk);
    model_check();
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_valid"}, W'(dn_valid), 0);
    chk({tag, "_count"}, W'(count), 0);
    chk({tag, "_ready"}, W'(up_ready), 1);
    chk({tag, "_afull"}, W'(almost_full), 0);
    chk({tag, "_data"}, dn_data, 0);
  endtask

  initial begin
    logic wr, rd;
    int idx, wrs, cycles;
    logic ok;

    // reset with the clock stopped
    #1 rst = 1'b1;
    #2 reset_literals("rst0");
    #1 rst = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    model_check();

    // fill 1..4 with consumer stalled
    cyc(1, 1, 0, wr, rd);
    chk("fill_c1", W'(count), 1);
    chk("fill_af1", W'(almost_full), 0);
    cyc(1, 2, 0, wr, rd);
    chk("fill_c2", W'(count), 2);
    cyc(1, 3, 0, wr, rd);
    chk("fill_c3", W'(count), 3);
    chk("fill_af3", W'(almost_full), 1);
    cyc(1, 4, 0, wr, rd);
    chk("fill_c4", W'(count), 4);
    chk("fill_rdy", W'(up_ready), 0);
    chk("fill_head", dn_data, 1);
    cyc(1, 5, 0, wr, rd);
    cyc(1, 5, 0, wr, rd);
    chk("no5_count", W'(count), 4);

    // drain 1..4 in order
    cyc(0, 0, 1, wr, rd);
    chk("drain_rdy", W'(up_ready), 1);
    chk("drain_h2", dn_data, 2);
    cyc(0, 0, 1, wr, rd);
    chk("drain_h3", dn_data, 3);
    cyc(0, 0, 1, wr, rd);
    chk("drain_h4", dn_data, 4);
    cyc(0, 0, 1, wr, rd);
    chk("drain_empty", W'(dn_valid), 0);
    ok = (rx.size() == 4) && rx[0] == 1 && rx[1] == 2 && rx[2] == 3 && rx[3] == 4;
    chk("drain_order", W'(ok), 1);
    cyc(1, 5, 0, wr, rd);
    chk("w5_count", W'(count), 1);
    chk("w5_data", dn_data, 5);

    // overlap at count 2
    cyc(1, 6, 0, wr, rd);
    rx.delete();
    cyc(1, 7, 1, wr, rd);
    chk("ovl_c1", W'(count), 2);
    chk("ovl_h1", dn_data, 6);
    cyc(1, 8, 1, wr, rd);
    chk("ovl_c2", W'(count), 2);
    chk("ovl_h2", dn_data, 7);
    cyc(0, 0, 1, wr, rd);
    cyc(0, 0, 1, wr, rd);
    ok = (rx.size() == 4) && rx[0] == 5 && rx[1] == 6 && rx[2] == 7 && rx[3] == 8;
    chk("ovl_order", W'(ok), 1);
    chk("ovl_empty", W'(count), 0);

    // random stream of 100 words
    rx.delete();
    idx = 0; wrs = 0; cycles = 0; maxc = 0;
    while (rx.size() < 100 && cycles < 4000) begin
      cyc((idx < 100) && $urandom_range(1), W'(1000 + idx),
          $urandom_range(1) == 1, wr, rd);
      if (wr) begin idx++; wrs++; end
      cycles++;
    end
    chk("strm_n", W'(rx.size()), 100);
    ok = 1'b1;
    foreach (rx[k]) if (rx[k] !== W'(1000 + k)) ok = 1'b0;
    chk("strm_order", W'(ok), 1);
    chk("strm_wraps", W'(wrs / DEPTH >= 20), 1);
    chk("strm_max", W'(maxc <= DEPTH), 1);

    // reset in the middle of a stream at count 3
    cyc(1, 32'h11, 0, wr, rd);
    cyc(1, 32'h22, 0, wr, rd);
    cyc(1, 32'h33, 0, wr, rd);
    up_valid = 1'b0;
    chk("pre_rst_c", W'(count), 3);
    #2 rst = 1'b1;
    #1 reset_literals("rst1");
    q.delete();
    #1 rst = 1'b0;
    cyc(1, 32'hA5, 0, wr, rd);
    chk("post_c", W'(count), 1);
    chk("post_v", W'(dn_valid), 1);
    chk("post_d", dn_data, 32'hA5);
    cyc(0, 0, 1, wr, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
